// File: rtl/apb4_mem_slave_pkg.sv
// Shared definitions for the APB4 memory slave.
//   apb_state_e : two-state transfer FSM encoding (IDLE, ACCESS)
//   CNT_W       : width of the wait-cycle counter (wait counts 0..15)
package apb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/apb4_mem_slave_if.sv
// APB4 bus bundle between a master and the memory slave.
//   psel/penable/pwrite/paddr/pwdata/pstrb : master -> slave request
//   prdata/pready/pslverr                  : slave -> master response
interface apb4_mem_slave_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_mem_slave_byte_ram.sv
// Byte-strobed storage: one synchronous write port with per-byte enables and
// one asynchronous (combinational) read port. Contents are never reset.
//   clk   : write clock
//   we    : write enable (qualified per lane by wstrb)
//   waddr : write word address
//   wstrb : byte-lane enables
//   wdata : write data
//   raddr : read word address
//   rdata : read data, combinational from raddr
module apb_byte_ram #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 64,
  localparam int AW     = $clog2(DEPTH),
  localparam int NB     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [NB-1:0]     wstrb,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // One independent byte-wide array per lane keeps every lane single-driver.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we && wstrb[gi]) begin
        lane_mem[waddr] <= wdata[8*gi +: 8];
      end
    end

    assign rdata[8*gi +: 8] = lane_mem[raddr];
  end

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 memory-mapped slave with configurable read/write wait states,
// byte-strobed writes, misaligned/out-of-range error responses and a
// saturating error counter.
//   pclk      : clock
//   preset    : asynchronous active-high reset
//   apb       : APB4 slave bus (request in, prdata/pready/pslverr out)
//   err_count : saturating count of error completions
module apb4_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1
) (
  input  logic                  pclk,
  input  logic                  preset,
  apb4_mem_slave_if.slave       apb,
  output logic [15:0]           err_count
);

  localparam int OFF   = $clog2(DATA_W / 8);
  localparam int AW    = $clog2(DEPTH);
  localparam int IDX_W = ADDR_W - OFF;

  // Elaboration-time parameter legality.
  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("apb4_mem_slave: DATA_W must be 32 or 64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("apb4_mem_slave: DEPTH must be a power of 2 (>= 2)");
  end
  if (RD_WAIT < 0 || RD_WAIT > 15 || WR_WAIT < 0 || WR_WAIT > 15) begin : g_bad_wait
    $error("apb4_mem_slave: wait counts must be 0..15");
  end

  apb_state_e         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [15:0]        err_count_reg;

  logic [IDX_W-1:0]   word_idx;
  logic               misaligned;
  logic               out_of_range;
  logic               access_err;
  logic [CNT_W-1:0]   target;
  logic               pready_int;
  logic               xfer_done;
  logic               ram_we;
  logic [DATA_W-1:0]  ram_rdata;

  // Address decode.
  assign word_idx   = apb.paddr[ADDR_W-1:OFF];
  assign misaligned = |apb.paddr[OFF-1:0];

  // Any set bit above the RAM address range means index >= DEPTH.
  if (IDX_W > AW) begin : g_range
    assign out_of_range = |word_idx[IDX_W-1:AW];
  end else begin : g_no_range
    assign out_of_range = 1'b0;
  end

  assign access_err = misaligned | out_of_range;

  // Wait target follows the live pwrite so reads and writes each get their own count.
  assign target     = apb.pwrite ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT);
  assign pready_int = (state_reg == ACCESS) && (cnt_reg == target);
  assign xfer_done  = pready_int && apb.psel && apb.penable;
  assign ram_we     = xfer_done && apb.pwrite && !access_err;

  assign apb.pready  = pready_int;
  assign apb.pslverr = pready_int && access_err;
  assign apb.prdata  = (pready_int && !apb.pwrite && !access_err) ? ram_rdata : '0;
  assign err_count   = err_count_reg;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      err_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A select with penable already high is treated as a setup phase.
          if (apb.psel) begin
            state_reg <= ACCESS;
            cnt_reg   <= '0;
          end
        end
        ACCESS: begin
          if (!apb.psel) begin
            // Abort: nothing written, nothing counted.
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (apb.penable) begin
            if (pready_int) begin
              state_reg <= IDLE;
              cnt_reg   <= '0;
            end else if (cnt_reg < target) begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase

      if (xfer_done && access_err && err_count_reg != 16'hFFFF) begin
        err_count_reg <= err_count_reg + 16'd1;
      end
    end
  end

  apb_byte_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (pclk),
    .we    (ram_we),
    .waddr (word_idx[AW-1:0]),
    .wstrb (apb.pstrb),
    .wdata (apb.pwdata),
    .raddr (word_idx[AW-1:0]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Self-checking bench for apb4_mem_slave: a default-wait instance (d=0) and a
// zero-wait instance (d=1) share one set of driven signals, gated by dsel.
module tb_apb4_mem_slave;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  int          dsel;

  logic        rdy, slv;
  logic [31:0] prd;
  logic [15:0] ecnt;
  logic [15:0] err_count0, err_count1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mm0 [64];
  logic [31:0] mm1 [64];
  int          exp_err0, exp_err1;

  always #5 pclk = ~pclk;

  apb4_mem_slave_if #(.ADDR_W(12), .DATA_W(32)) bus0 ();
  apb4_mem_slave_if #(.ADDR_W(12), .DATA_W(32)) bus1 ();

  assign bus0.psel    = psel && (dsel == 0);
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus0.pwdata  = pwdata;
  assign bus0.pstrb   = pstrb;
  assign bus1.psel    = psel && (dsel == 1);
  assign bus1.penable = penable;
  assign bus1.pwrite  = pwrite;
  assign bus1.paddr   = paddr;
  assign bus1.pwdata  = pwdata;
  assign bus1.pstrb   = pstrb;

  assign rdy  = (dsel == 1) ? bus1.pready  : bus0.pready;
  assign slv  = (dsel == 1) ? bus1.pslverr : bus0.pslverr;
  assign prd  = (dsel == 1) ? bus1.prdata  : bus0.prdata;
  assign ecnt = (dsel == 1) ? err_count1   : err_count0;

  apb4_mem_slave dut0 (
    .pclk      (pclk),
    .preset    (preset),
    .apb       (bus0),
    .err_count (err_count0)
  );

  apb4_mem_slave #(.RD_WAIT(0), .WR_WAIT(0)) dut1 (
    .pclk      (pclk),
    .preset    (preset),
    .apb       (bus1),
    .err_count (err_count1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One APB transfer; returns the response and the number of access cycles.
  task automatic xfer(input int d, input bit wr, input logic [11:0] addr,
                      input logic [31:0] wd, input logic [3:0] st, input bit skip_setup,
                      output logic [31:0] rdata, output logic slverr, output int cyc);
    dsel = d;
    @(negedge pclk);
    psel = 1'b1; penable = skip_setup; pwrite = wr;
    paddr = addr; pwdata = wd; pstrb = st;
    @(negedge pclk);
    penable = 1'b1; cyc = 1; #1;
    while (!rdy && cyc < 40) begin
      check("wait_quiet", {31'd0, slv, prd}, 64'd0);
      @(negedge pclk); cyc++; #1;
    end
    check("pready_seen", {63'd0, rdy}, 64'd1);
    rdata  = prd;
    slverr = slv;
  endtask

  task automatic go_idle();
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    #1;
  endtask

  // Transfer followed by one idle cycle, checked against the reference model.
  task automatic op(input int d, input bit wr, input logic [11:0] addr,
                    input logic [31:0] wd, input logic [3:0] st, input bit skip,
                    input string tag);
    int          idx, cyc, exp_cyc;
    bit          err;
    logic [31:0] exp_rd, rd;
    logic        sl;
    idx = int'(addr) / 4;
    err = (addr % 4 != 0) || (idx >= 64);
    exp_rd = 32'd0;
    if (!wr && !err) exp_rd = (d == 0) ? mm0[idx] : mm1[idx];
    exp_cyc = (d == 1) ? 1 : (wr ? 2 : 3);
    xfer(d, wr, addr, wd, st, skip, rd, sl, cyc);
    check($sformatf("%s_cycles", tag), 64'(cyc), 64'(exp_cyc));
    check($sformatf("%s_pslverr", tag), {63'd0, sl}, {63'd0, err});
    check($sformatf("%s_prdata", tag), {32'd0, rd}, {32'd0, exp_rd});
    if (wr && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (st[b]) begin
          if (d == 0) mm0[idx][8*b +: 8] = wd[8*b +: 8];
          else        mm1[idx][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end
    if (err) begin
      if (d == 0) exp_err0 = (exp_err0 < 65535) ? exp_err0 + 1 : 65535;
      else        exp_err1 = (exp_err1 < 65535) ? exp_err1 + 1 : 65535;
    end
    go_idle();
    check($sformatf("%s_err_count", tag), 64'(ecnt), 64'((d == 0) ? exp_err0 : exp_err1));
    $display("op %s d=%0d wr=%0b addr=%h wd=%h strb=%h -> rd=%h slverr=%0b cyc=%0d",
             tag, d, wr, addr, wd, st, rd, sl, cyc);
  endtask

  initial begin
    logic [31:0] rd;
    logic        sl;
    int          cyc, idx, offs;
    logic [31:0] saved;

    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; dsel = 0;
    exp_err0 = 0; exp_err1 = 0;
    #2;
    check("reset_pready",  {63'd0, bus0.pready},  64'd0);
    check("reset_pslverr", {63'd0, bus0.pslverr}, 64'd0);
    check("reset_prdata",  {32'd0, bus0.prdata},  64'd0);
    check("reset_err_cnt", 64'(err_count0),       64'd0);
    repeat (2) @(negedge pclk);
    preset = 1'b0;

    // Give every word a known value.
    for (int i = 0; i < 64; i++) op(0, 1'b1, 12'(i * 4), $urandom, 4'hF, 1'b0, "preload");

    // Basic write/read and byte strobes.
    op(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 1'b0, "wr_deadbeef");
    op(0, 1'b0, 12'h010, 32'h0,        4'h0, 1'b0, "rd_deadbeef");
    check("deadbeef_model", {32'd0, mm0[4]}, 64'h0000_0000_DEAD_BEEF);
    op(0, 1'b1, 12'h010, 32'h11223344, 4'h5, 1'b0, "wr_strb5");
    op(0, 1'b0, 12'h010, 32'h0,        4'h0, 1'b0, "rd_strb5");
    check("strb5_model", {32'd0, mm0[4]}, 64'h0000_0000_DE22_BE44);
    op(0, 1'b1, 12'h014, 32'hCAFEF00D, 4'h0, 1'b0, "wr_strb0");

    // Error responses.
    op(0, 1'b1, 12'h100, 32'h12345678, 4'hF, 1'b0, "wr_oob");
    op(0, 1'b0, 12'h012, 32'h0,        4'h0, 1'b0, "rd_misaligned");
    check("err_count_two", 64'(err_count0), 64'd2);
    op(0, 1'b0, 12'h010, 32'h0,        4'h0, 1'b0, "rd_after_err");

    // Select with penable already high, from IDLE.
    op(0, 1'b1, 12'h0FC, 32'h0BADC0DE, 4'hF, 1'b1, "wr_nosetup");
    op(0, 1'b0, 12'h0FC, 32'h0,        4'h0, 1'b1, "rd_nosetup");

    // Randomized traffic.
    for (int i = 0; i < 120; i++) begin
      idx  = $urandom_range(0, 71);
      offs = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      op(0, 1'($urandom_range(0, 1)), 12'(idx * 4 + offs), $urandom,
         4'($urandom_range(0, 15)), 1'($urandom_range(0, 7) == 0), "rand");
    end

    // Abort after access cycle 1 of a write.
    saved = mm0[8];
    dsel = 0;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h020; pwdata = 32'h55; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1; #1;
    check("abort_pready_c1", {63'd0, rdy}, 64'd0);
    go_idle();
    check("abort_err_count", 64'(ecnt), 64'(exp_err0));
    op(0, 1'b0, 12'h020, 32'h0, 4'h0, 1'b0, "rd_after_abort");
    check("abort_mem_kept", {32'd0, mm0[8]}, {32'd0, saved});
    $display("abort write 0x020 -> prior value %h kept", saved);

    // Reset during a write: no memory update.
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h87654321; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1; #1;
    check("wrrst_pready_c1", {63'd0, rdy}, 64'd0);
    #1 preset = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; preset = 1'b0;
    exp_err0 = 0; exp_err1 = 0;
    $display("reset during write to 0x010");

    // Build up an error count, then reset during read wait cycle 1.
    op(0, 1'b0, 12'h013, 32'h0, 4'h0, 1'b0, "pre_rst_err");
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h010;
    @(negedge pclk);
    penable = 1'b1; #1;
    check("rdrst_pready_c1", {63'd0, rdy}, 64'd0);
    check("rdrst_err_before", 64'(ecnt), 64'd1);
    #1 preset = 1'b1;
    #1;
    check("rdrst_pready",  {63'd0, rdy}, 64'd0);
    check("rdrst_prdata",  {32'd0, prd}, 64'd0);
    check("rdrst_pslverr", {63'd0, slv}, 64'd0);
    check("rdrst_err_cnt", 64'(ecnt),    64'd0);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; preset = 1'b0;
    exp_err0 = 0;
    $display("reset during read wait cycle 1");
    op(0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0, "rd_after_rst");

    // Zero-wait instance: back-to-back write then read.
    xfer(1, 1'b1, 12'h03C, 32'hA5A5A5A5, 4'hF, 1'b0, rd, sl, cyc);
    check("b2b_wr_cycles",  64'(cyc), 64'd1);
    check("b2b_wr_pslverr", {63'd0, sl}, 64'd0);
    mm1[15] = 32'hA5A5A5A5;
    xfer(1, 1'b0, 12'h03C, 32'h0, 4'h0, 1'b0, rd, sl, cyc);
    check("b2b_rd_cycles",  64'(cyc), 64'd1);
    check("b2b_rd_prdata",  {32'd0, rd}, {32'd0, mm1[15]});
    check("b2b_rd_pslverr", {63'd0, sl}, 64'd0);
    go_idle();
    $display("zero-wait back-to-back 0x03C -> rd=%h", rd);
    op(1, 1'b1, 12'h101, 32'h1, 4'hF, 1'b0, "zw_err");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/apb4_mem_slave.md
APB4_MEM_SLAVE -- requirements
Module: apb4_mem_slave

Interface
REQ-001 The block SHALL have one clock, pclk, and one reset, preset, which is asynchronous and active-high.
REQ-002 Parameter ADDR_W, default 12, SHALL set the paddr width in bits.
REQ-003 Parameter DATA_W, default 32, SHALL set the data width and SHALL be limited to 32 or 64.
REQ-004 Parameter DEPTH, default 64, SHALL set the number of DATA_W words and SHALL be a power of 2.
REQ-005 Parameter RD_WAIT, default 2, SHALL set the number of read wait cycles (0..15).
REQ-006 Parameter WR_WAIT, default 1, SHALL set the number of write wait cycles (0..15).
REQ-007 The ports SHALL be as follows:
- pclk  in  1  clock
- preset  in  1  asynchronous active-high reset
- psel  in  1  slave select
- penable  in  1  access phase
- pwrite  in  1  1=write, 0=read
- paddr  in  ADDR_W  byte address
- pwdata  in  DATA_W  write data
- pstrb  in  DATA_W/8  byte-lane write strobes
- prdata  out  DATA_W  read data
- pready  out  1  transfer completes this cycle
- pslverr  out  1  error response, valid only when pready=1
- err_count  out  16  saturating count of error responses

Function
REQ-008 Word index SHALL be paddr >> log2(DATA_W/8), where OFF is the LSB count log2(DATA_W/8).
REQ-009 An access SHALL be an error if paddr[OFF-1:0] != 0 (misaligned) or word index >= DEPTH (out of range).
REQ-010 The FSM SHALL have two states: IDLE and ACCESS.
REQ-011 In IDLE, psel=1 and penable=0 (setup phase) SHALL move the FSM to ACCESS and clear the wait counter cnt to 0.
REQ-012 In ACCESS, target SHALL be WR_WAIT when pwrite=1 and RD_WAIT when pwrite=0.
REQ-013 pready SHALL equal (state==ACCESS and cnt==target); pready SHALL be 0 in IDLE.
REQ-014 In ACCESS with psel=1, penable=1 and cnt<target, cnt SHALL increment by 1.
REQ-015 Each transfer SHALL therefore have exactly target wait cycles, so pready rises on access cycle target+1.
REQ-016 In ACCESS with psel=1, penable=1 and pready=1, the FSM SHALL return to IDLE on the next edge.
- A setup phase in the cycle immediately after completion SHALL be accepted (back-to-back transfers).
REQ-017 In ACCESS with psel=0 (abort), the FSM SHALL return to IDLE with no memory write and no err_count change.
REQ-018 In IDLE, psel=1 and penable=1 without a preceding setup SHALL be treated as a setup phase.
REQ-019 On a write completion (pready=1, pwrite=1, no error), byte lane i SHALL be written from pwdata[8i+7:8i] only when pstrb[i]=1.
REQ-020 A write with pstrb=0 SHALL be a legal no-op with pslverr=0.
REQ-021 When pready=1, pwrite=0 and no error, prdata SHALL equal mem[index]; in every other cycle prdata SHALL be 0.
REQ-022 When pready=1 and the access is an error, pslverr SHALL be 1, prdata SHALL be 0, and memory SHALL be unchanged.
- Errors SHALL use the same wait count as normal accesses.
REQ-023 pslverr SHALL be 0 whenever pready=0.
REQ-024 err_count SHALL increment by 1 on the edge after each error completion and SHALL saturate at 16'hFFFF.
REQ-025 Memory contents SHALL persist across transfers; no read-modify-write hazard SHALL exist between back-to-back write and read.

Reset
REQ-026 While preset=1, the block SHALL immediately hold: state=IDLE, cnt=0, pready=0, pslverr=0, prdata=0, err_count=0.
REQ-027 Reset asserted mid-transfer SHALL abort it with no memory write.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 The first setup phase after preset falls SHALL be accepted normally.

Structure
REQ-030 A shared package apb_pkg SHALL hold the FSM state enum (IDLE, ACCESS) and the wait-count width constant.
REQ-031 The byte-strobed storage SHALL be a sub-module apb_byte_ram with DATA_W and DEPTH parameters, one write port with byte enables, and an asynchronous read port.

Verification (defaults unless stated)
REQ-032 Write 0xDEADBEEF to 0x010 with pstrb=0xF: pready=1 on access cycle 2.
- Read 0x010: pready=1 on access cycle 3, prdata=0xDEADBEEF, pslverr=0.
REQ-033 Write 0x11223344 to 0x010 with pstrb=0x5, then read 0x010: prdata=0xDE22BE44.
REQ-034 Write to 0x100 (index 64): pslverr=1 with pready, err_count=1.
- Then read 0x012 (misaligned): pslverr=1, prdata=0, err_count=2; memory unchanged.
REQ-035 Setup a write of 0x55 to 0x020, then drop psel after access cycle 1: a later read of 0x020 returns the prior value and err_count is unchanged.
REQ-036 Assert preset during read wait cycle 1: pready, prdata and err_count go to 0 without a clock edge; the next read of 0x010 completes normally.
REQ-037 With RD_WAIT=WR_WAIT=0, a back-to-back write then read of 0x3C (0xA5A5A5A5) with no idle cycle: pready=1 on each first access cycle and prdata=0xA5A5A5A5.
